// File: rtl/shift8_collector_if.sv
// Bus for the shift8_collector: serial/parallel controls in, window taps and fill status out.
// The master side drives the controls; the slave side (the collector) drives the window.
interface shift8_collector_if;
   logic       clear;
   logic       load;
   logic [7:0] din;
   logic       shift;
   logic       sin;
   logic [7:0] q;
   logic [3:0] count;
   logic       valid;

   modport master (
      output clear, load, din, shift, sin,
      input  q, count, valid
   );

   modport slave (
      input  clear, load, din, shift, sin,
      output q, count, valid
   );
endinterface

// File: rtl/shift8_collector.sv
// Serial-to-parallel 8-bit window feeding an 8-input AND gate.
// Tracks how many real bits are held and flags when the window is full.
module shift8_collector #(
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   shift8_collector_if.slave    bus
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_q;
   logic [3:0]  r_count;
   logic        r_valid;

   state_t      w_state_next;
   logic [7:0]  w_q_next;
   logic [3:0]  w_count_next;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= EMPTY;
         r_q     <= INIT;
         r_count <= 4'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_q     <= w_q_next;
         r_count <= w_count_next;
         r_valid <= (w_state_next == FULL);
      end
   end

   // Priority clear > load > shift; with no control active everything holds.
   always_comb begin
      w_state_next = r_state;
      w_q_next     = r_q;
      w_count_next = r_count;
      if (bus.clear) begin
         w_state_next = EMPTY;
         w_q_next     = INIT;
         w_count_next = 4'd0;
      end else if (bus.load) begin
         w_state_next = FULL;
         w_q_next     = bus.din;
         w_count_next = 4'd8;
      end else if (bus.shift) begin
         w_q_next = {r_q[6:0], bus.sin};
         case (r_state)
            EMPTY: begin
               w_state_next = FILLING;
               w_count_next = 4'd1;
            end
            FILLING: begin
               w_count_next = r_count + 4'd1;
               w_state_next = (r_count == 4'd7) ? FULL : FILLING;
            end
            FULL: begin
               // Window slides; count saturates at 8.
               w_count_next = 4'd8;
            end
            default: begin
               w_state_next = EMPTY;
               w_count_next = 4'd0;
            end
         endcase
      end
   end

   assign bus.q     = r_q;
   assign bus.count = r_count;
   assign bus.valid = r_valid;

endmodule

// File: tb/tb_shift8_collector.sv
// Scoreboard bench for shift8_collector: directed scenarios plus random controls,
// expectations from a window/count reference model, checked by a separate monitor.
module tb_shift8_collector;

   localparam logic [7:0] INIT_VAL = 8'hA5;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] c;
      logic       v;
   } exp_t;

   logic clk;
   logic reset;
   shift8_collector_if bus();

   int errors = 0;
   int checks = 0;

   exp_t sb_q[$];

   // Reference model: window contents and number of bits held.
   logic [7:0] m_win;
   int         m_cnt;

   shift8_collector #(.INIT(INIT_VAL)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model_exp();
      exp_t e;
      e.q = m_win;
      e.c = 4'(m_cnt);
      e.v = (m_cnt == 8);
      return e;
   endfunction

   task automatic check_now(input string name, input exp_t e);
      checks++;
      if (bus.q !== e.q || bus.count !== e.c || bus.valid !== e.v) begin
         errors++;
         $display("FAIL %s: got q=%h count=%0d valid=%b, expected q=%h count=%0d valid=%b",
                  name, bus.q, bus.count, bus.valid, e.q, e.c, e.v);
      end else begin
         $display("ok   %s: q=%h count=%0d valid=%b", name, bus.q, bus.count, bus.valid);
      end
   endtask

   // Monitor: the registered outputs present one result per cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_now("sb", e);
         checks++;
         if ((&bus.q) !== (&e.q)) begin
            errors++;
            $display("FAIL gate: got and8=%b, expected and8=%b", &bus.q, &e.q);
         end
      end
   end

   task automatic step(input logic c, input logic l, input logic [7:0] d,
                       input logic s, input logic si);
      @(negedge clk);
      #1;
      bus.clear = c; bus.load = l; bus.din = d; bus.shift = s; bus.sin = si;
      @(posedge clk);
      if (c) begin
         m_win = INIT_VAL;
         m_cnt = 0;
      end else if (l) begin
         m_win = d;
         m_cnt = 8;
      end else if (s) begin
         m_win = {m_win[6:0], si};
         m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      end
      sb_q.push_back(model_exp());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Mid-cycle reset pulse; outputs must change before any clock edge.
   task automatic pulse_reset();
      exp_t e;
      @(negedge clk);
      #1;
      bus.clear = 0; bus.load = 0; bus.shift = 0; bus.sin = 0;
      #1;
      reset = 1'b1;
      #1;
      m_win = INIT_VAL;
      m_cnt = 0;
      sb_q.delete();
      e = model_exp();
      check_now("async_reset", e);
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] fill_bits;
      exp_t e;
      bus.clear = 0; bus.load = 0; bus.din = 0; bus.shift = 0; bus.sin = 0;
      reset = 1'b1;
      m_win = INIT_VAL;
      m_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      e = model_exp();
      check_now("reset_values", e);

      // Fill with 1,0,1,1,0,0,1,1 -> 8'b10110011
      fill_bits = 8'b10110011;
      for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 8'h00, 1'b1, fill_bits[i]);
      @(negedge clk);
      #1;
      e.q = 8'b10110011; e.c = 4'd8; e.v = 1'b1;
      check_now("fill_result", e);

      // Sliding and saturation
      step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      e.q = 8'hFE; e.c = 4'd8; e.v = 1'b1;
      check_now("slide_fe", e);

      // Priority
      step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      e.q = 8'h3C; e.c = 4'd8; e.v = 1'b1;
      check_now("load_over_shift", e);

      // Reset mid-fill
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'($urandom_range(1)));
      pulse_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'($urandom_range(1)));

      // Hold at count 3
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) idle();

      // Random controls, clear/load kept rare so fills and saturation both occur
      for (int i = 0; i < 300; i++) begin
         logic c, l, s, si;
         logic [7:0] d;
         c  = ($urandom_range(19) == 0);
         l  = ($urandom_range(14) == 0);
         s  = ($urandom_range(3) != 0);
         si = 1'($urandom_range(1));
         d  = 8'($urandom);
         step(c, l, d, s, si);
         if (i == 150) pulse_reset();
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
